// File: rtl/network_pkg.sv
// network_pkg: sizing helpers and weight field positions for the network neuron core.
package network_pkg;
    function automatic int bal_width(input int width, input int height);
        return $clog2(height * (2 ** width));
    endfunction
    function automatic int scan_len(input int width, input int height);
        return height * (2 ** width);
    endfunction
    // weight word: [width] is the sign (1 = inhibitory), [width-1:0] the magnitude
    function automatic int sign_pos(input int width);
        return width;
    endfunction
    function automatic int mag_msb(input int width);
        return width - 1;
    endfunction
endpackage

// File: rtl/network_sat_updown_counter.sv
// sat_updown_counter: up/down counter clamped to [0, 2**BW-1], loadable to its midpoint.
module sat_updown_counter
    import network_pkg::*;
#(
    parameter int BW = 11
) (
    input  logic          clk,
    input  logic          inc,
    input  logic          dec,
    input  logic          load_mid,
    output logic [BW-1:0] count
);
    always_ff @(posedge clk) begin
        if (load_mid) count <= {1'b1, {(BW-1){1'b0}}};
        else if (inc && count != '1) count <= count + 1'b1;
        else if (dec && count != '0) count <= count - 1'b1;
    end
endmodule

// File: rtl/network.sv
// network: single-neuron binary classifier; scans pixels serially, stepping a
// saturating balance by each active pixel's weight in unary, then thresholds at the midpoint.
module network
    import network_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int HEIGHT = 7,
    parameter bit [WIDTH:0] WEIGHTS [0:HEIGHT-1] = '{default: 60}
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [HEIGHT-1:0]                    pixels,
    output logic                                 neuron_out,
    output logic [bal_width(WIDTH, HEIGHT)-1:0]  balance_out
);
    localparam int BW = bal_width(WIDTH, HEIGHT);
    localparam int SCAN = scan_len(WIDTH, HEIGHT);
    localparam int CW = $clog2(SCAN + 1);
    localparam int PW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
    localparam logic [BW-1:0] MID = BW'(1) << (BW - 1);

    logic [CW-1:0]  c;
    logic           done;
    logic [PW-1:0]  p;
    logic [WIDTH-1:0] k;
    logic [WIDTH:0] w;
    logic           step;

    assign p = PW'(c >> WIDTH);
    assign k = c[WIDTH-1:0];
    assign w = WEIGHTS[p];
    assign step = !done && pixels[p] && (k < w[mag_msb(WIDTH):0]);

    sat_updown_counter #(.BW(BW)) u_bal (
        .clk      (clk),
        .inc      (step && !w[sign_pos(WIDTH)]),
        .dec      (step && w[sign_pos(WIDTH)]),
        .load_mid (!rst),
        .count    (balance_out)
    );

    // the last scan cycle can never step (k = 2**WIDTH-1 is not below any magnitude),
    // so the register value seen here is already the final balance
    always_ff @(posedge clk) begin
        if (!rst) begin
            c <= '0;
            done <= 1'b0;
            neuron_out <= 1'b0;
        end else if (!done) begin
            if (c == CW'(SCAN - 1)) begin
                done <= 1'b1;
                neuron_out <= balance_out > MID;
            end else c <= c + 1'b1;
        end
    end
endmodule

// File: tb/tb_network.sv
// tb_network: four network instances with different weight sets, checked every cycle
// against a per-pixel closed-form balance model, plus hand-computed literal checkpoints.
module tb_network;
    localparam int SCAN = 1792;
    localparam int MID = 1024;
    localparam int MAXB = 2047;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] pixels = 7'h00;
    logic [10:0] bal [4];
    logic nout [4];

    bit [8:0] wt [4] = '{9'd60, 9'd260, 9'd255, 9'd511};

    int n = 0;
    logic [6:0] mpix = 7'h00;
    bit chk_en = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    network u_def (.clk(clk), .rst(rst), .pixels(pixels), .neuron_out(nout[0]), .balance_out(bal[0]));
    network #(.WEIGHTS('{default: 9'd260})) u_inh (.clk(clk), .rst(rst), .pixels(pixels), .neuron_out(nout[1]), .balance_out(bal[1]));
    network #(.WEIGHTS('{default: 9'd255})) u_sp (.clk(clk), .rst(rst), .pixels(pixels), .neuron_out(nout[2]), .balance_out(bal[2]));
    network #(.WEIGHTS('{default: 9'd511})) u_sn (.clk(clk), .rst(rst), .pixels(pixels), .neuron_out(nout[3]), .balance_out(bal[3]));

    // elapsed scan cycles since reset release; pixels captured for the run while in reset
    always @(posedge clk) begin
        if (!rst) begin
            n <= 0;
            mpix <= pixels;
        end else if (n < SCAN) n <= n + 1;
    end

    // each pixel contributes min(cycles spent on it, magnitude) unit steps in one
    // direction, so clamping once per pixel reproduces per-step saturation exactly
    function automatic int exp_bal(input int j, input logic [6:0] pix, input int cyc);
        int b;
        int s;
        int mag;
        b = MID;
        mag = int'(wt[j][7:0]);
        for (int i = 0; i < 7; i++) begin
            if (pix[i]) begin
                s = cyc - i * 256;
                if (s < 0) s = 0;
                if (s > mag) s = mag;
                if (wt[j][8]) b = (b - s < 0) ? 0 : b - s;
                else b = (b + s > MAXB) ? MAXB : b + s;
            end
        end
        return b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("model_bal[%0d] n=%0d", j, n), int'(bal[j]), exp_bal(j, mpix, n));
                chk($sformatf("model_out[%0d] n=%0d", j, n), int'(nout[j]),
                    (n >= SCAN && exp_bal(j, mpix, SCAN) > MID) ? 1 : 0);
            end
        end
    end

    task automatic wait_n(input int target);
        int k;
        k = 0;
        while (n != target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (n != target) chk("timeout", n, target);
    endtask

    task automatic start_run(input logic [6:0] pix);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pixels = pix;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_bal", int'(bal[0]), 1024);
        chk("reset_out", int'(nout[0]), 0);
        rst = 1'b1;
    endtask

    initial begin
        start_run(7'h7F);
        wait_n(256);
        chk("def_bal_256", int'(bal[0]), 1084);
        wait_n(SCAN - 1);
        chk("def_out_pre", int'(nout[0]), 0);
        wait_n(SCAN);
        chk("def_final", int'(bal[0]), 1444);
        chk("def_out", int'(nout[0]), 1);
        chk("inh_final", int'(bal[1]), 996);
        chk("inh_out", int'(nout[1]), 0);
        chk("satp_final", int'(bal[2]), 2047);
        chk("satp_out", int'(nout[2]), 1);
        chk("satn_final", int'(bal[3]), 0);
        chk("satn_out", int'(nout[3]), 0);
        repeat (5) @(negedge clk);
        chk("def_hold", int'(bal[0]), 1444);

        start_run(7'h00);
        wait_n(SCAN);
        chk("zero_bal", int'(bal[1]), 1024);
        chk("zero_out", int'(nout[1]), 0);

        start_run(7'h7F);
        wait_n(500);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_bal", int'(bal[0]), 1024);
        chk("midrst_out", int'(nout[0]), 0);
        rst = 1'b1;
        wait_n(256);
        chk("midrst_bal_256", int'(bal[0]), 1084);
        wait_n(SCAN);
        chk("midrst_final", int'(bal[0]), 1444);
        chk("midrst_out_fin", int'(nout[0]), 1);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
